// File: rtl/wb_ctrl.sv
// Writeback controller: merges single-cycle EX results with buffered long-latency results onto the register-file write port.
// Optional macro WB_LU_BYPASS_EN lets an LU result skip the empty FIFO and write one edge after its handshake.
module wb_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        ex_stall_o,
  output logic        busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    fifo_addr_q [FIFO_DEPTH];
  logic [4:0]    fifo_addr_d [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic          reg_wen_q, reg_wen_d;
  logic [4:0]    reg_waddr_q, reg_waddr_d;
  logic [31:0]   reg_wdata_q, reg_wdata_d;

  logic fifo_empty;
  logic fifo_full;
  logic ex_req;
  logic ex_win;
  logic pop;
  logic lu_take;
  logic bypass;
  logic push;

  assign fifo_empty  = (count_q == CW'(0));
  assign fifo_full   = (count_q == DEPTH_C);
  assign lu_ready_o  = !fifo_full;
  assign ex_stall_o  = (starve_q == SMAX_C);
  assign busy_o      = !fifo_empty;
  assign reg_wen_o   = reg_wen_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;

  // Arbitration, FIFO bookkeeping and starvation tracking for the next edge.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    reg_wen_d   = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;

    // Writes to x0 are dropped at the source; the LU handshake still completes.
    ex_req  = ex_wen_i && (ex_waddr_i != 5'd0);
    ex_win  = ex_req && !ex_stall_o;
    pop     = !ex_win && !fifo_empty;
    lu_take = lu_valid_i && lu_ready_o && (lu_waddr_i != 5'd0);
`ifdef WB_LU_BYPASS_EN
    bypass  = lu_take && fifo_empty && !ex_win;
`else
    bypass  = 1'b0;
`endif
    push    = lu_take && !bypass;

    if (ex_win) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = ex_waddr_i;
      reg_wdata_d = ex_wdata_i;
    end else if (pop) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = fifo_addr_q[rd_ptr_q];
      reg_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = lu_waddr_i;
      reg_wdata_d = lu_wdata_i;
    end else begin
      reg_wen_d   = 1'b0;
    end

    if (push) begin
      fifo_addr_d[wr_ptr_q] = lu_waddr_i;
      fifo_data_d[wr_ptr_q] = lu_wdata_i;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d              = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The head only loses to EX, so a non-empty cycle without a pop is a lost cycle.
    if (pop || fifo_empty) begin
      starve_d = SW'(0);
    end else if (ex_win && (starve_q != SMAX_C)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers; reset drops any buffered results without writing them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= AW'(0);
      rd_ptr_q    <= AW'(0);
      count_q     <= CW'(0);
      starve_q    <= SW'(0);
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= 32'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= 5'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      reg_wen_q   <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_wb_ctrl;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wen_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        ex_stall_o;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ex_wen_i(ex_wen_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
    .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .ex_stall_o(ex_stall_o), .busy_o(busy_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending LU results, lost-cycle count, expected write port.
  logic [36:0] m_q[$];
  int          m_starve;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        stall_was;
  logic        ready_was;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic m_ready();
    return m_q.size() < DEPTH;
  endfunction

  function automatic logic m_stall();
    return m_starve == SMAX;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_wen    = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
  endtask

  task automatic model_step();
    logic ex_req, empty, take, stall;
    logic [36:0] h;
    if (rst) begin
      model_reset();
    end else begin
      stall  = m_stall();
      empty  = (m_q.size() == 0);
      ex_req = ex_wen_i && (ex_waddr_i != 5'd0);
      take   = lu_valid_i && m_ready() && (lu_waddr_i != 5'd0);
      if (ex_req && !stall) begin
        m_wen  = 1'b1;
        m_addr = ex_waddr_i;
        m_data = ex_wdata_i;
        if (!empty) m_starve = m_starve + 1;
      end else if (!empty) begin
        h = m_q.pop_front();
        m_wen  = 1'b1;
        m_addr = h[36:32];
        m_data = h[31:0];
        m_starve = 0;
      end
`ifdef WB_LU_BYPASS_EN
      else if (take) begin
        m_wen  = 1'b1;
        m_addr = lu_waddr_i;
        m_data = lu_wdata_i;
        take   = 1'b0;
      end
`endif
      else begin
        m_wen = 1'b0;
      end
      if (take) m_q.push_back({lu_waddr_i, lu_wdata_i});
    end
  endtask

  // Advance one edge, update the model, then settle 1 time unit past the edge.
  task automatic cyc();
    stall_was = m_stall();
    ready_was = m_ready();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ex_drive(input int k);
    if (!stall_was) ex_wdata_i = 32'h0000_0A00 + 32'(k);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("reg_wen",   32'(reg_wen_o),   32'(m_wen));
      chk("reg_waddr", 32'(reg_waddr_o), 32'(m_addr));
      chk("reg_wdata", reg_wdata_o,      m_data);
      chk("lu_ready",  32'(lu_ready_o),  32'(m_ready()));
      chk("ex_stall",  32'(ex_stall_o),  32'(m_stall()));
      chk("busy",      32'(busy_o),      32'(m_q.size() != 0));
    end
  end

  initial begin
    rst = 1'b1;
    ex_wen_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    lu_valid_i = 1'b0; lu_waddr_i = 5'd0; lu_wdata_i = 32'd0;
    stall_was = 1'b0; ready_was = 1'b1;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_wen",   32'(reg_wen_o),   32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    chk("rst_wdata", reg_wdata_o,      32'd0);
    chk("rst_ready", 32'(lu_ready_o),  32'd1);
    chk("rst_stall", 32'(ex_stall_o),  32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);

    // EX write: visible one edge later, for one cycle.
    ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234_5678;
    cyc();
    ex_wen_i = 1'b0;
    chk("ex_wen",   32'(reg_wen_o),   32'd1);
    chk("ex_waddr", 32'(reg_waddr_o), 32'd5);
    chk("ex_wdata", reg_wdata_o,      32'h1234_5678);
    cyc();
    chk("ex_wen_off", 32'(reg_wen_o), 32'd0);

    // LU result with EX idle.
    lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'hDEAD_BEEF;
    cyc();
    lu_valid_i = 1'b0;
`ifdef WB_LU_BYPASS_EN
    chk("byp_wen",   32'(reg_wen_o),   32'd1);
    chk("byp_waddr", 32'(reg_waddr_o), 32'd7);
    chk("byp_busy",  32'(busy_o),      32'd0);
    cyc();
`else
    chk("lu_busy1",  32'(busy_o),      32'd1);
    chk("lu_wen1",   32'(reg_wen_o),   32'd0);
    cyc();
    chk("lu_wen2",   32'(reg_wen_o),   32'd1);
    chk("lu_waddr",  32'(reg_waddr_o), 32'd7);
    chk("lu_wdata",  reg_wdata_o,      32'hDEAD_BEEF);
    chk("lu_busy2",  32'(busy_o),      32'd0);
    cyc();
`endif
    chk("lu_wen_off", 32'(reg_wen_o), 32'd0);

    // Starvation: EX writes x10 every cycle while x1, x2, x3 wait.
    ex_wen_i = 1'b1; ex_waddr_i = 5'd10;
    lu_valid_i = 1'b1; lu_waddr_i = 5'd1; lu_wdata_i = 32'd1;
    ex_drive(0); cyc();
    lu_waddr_i = 5'd2; lu_wdata_i = 32'd2;
    ex_drive(1); cyc();
    chk("full_ready", 32'(lu_ready_o), 32'd0);
    lu_waddr_i = 5'd3; lu_wdata_i = 32'd3;
    for (int k = 2; k <= 4; k++) begin
      ex_drive(k); cyc();
    end
    chk("stall_on",   32'(ex_stall_o), 32'd1);
    chk("pre_stall",  reg_wdata_o,     32'h0000_0A04);
    ex_drive(5); cyc();
    chk("pop1_addr",  32'(reg_waddr_o), 32'd1);
    chk("pop1_data",  reg_wdata_o,      32'd1);
    chk("pop1_stall", 32'(ex_stall_o),  32'd0);
    chk("pop1_ready", 32'(lu_ready_o),  32'd1);
    ex_drive(6); cyc();
    lu_valid_i = 1'b0;
    chk("held_addr",  32'(reg_waddr_o), 32'd10);
    chk("held_data",  reg_wdata_o,      32'h0000_0A05);
    for (int k = 7; k <= 16; k++) begin
      ex_drive(k); cyc();
      if (k == 10) begin
        chk("pop2_addr", 32'(reg_waddr_o), 32'd2);
        chk("pop2_data", reg_wdata_o,      32'd2);
      end else if (k == 15) begin
        chk("pop3_addr", 32'(reg_waddr_o), 32'd3);
        chk("pop3_data", reg_wdata_o,      32'd3);
      end else begin
        chk("ex_addr", 32'(reg_waddr_o), 32'd10);
      end
    end
    ex_wen_i = 1'b0;
    repeat (2) cyc();

    // x0 from both sources: nothing written, LU handshake still accepted.
    ex_wen_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFF_FFFF;
    lu_valid_i = 1'b1; lu_waddr_i = 5'd0; lu_wdata_i = 32'h5555_5555;
    chk("x0_ready", 32'(lu_ready_o), 32'd1);
    cyc();
    ex_wen_i = 1'b0; lu_valid_i = 1'b0;
    chk("x0_wen",  32'(reg_wen_o), 32'd0);
    chk("x0_busy", 32'(busy_o),    32'd0);
    cyc();

    // Async reset with two buffered entries.
    ex_wen_i = 1'b1; ex_waddr_i = 5'd12; ex_wdata_i = 32'h0000_0C00;
    lu_valid_i = 1'b1; lu_waddr_i = 5'd4; lu_wdata_i = 32'h44;
    cyc();
    lu_waddr_i = 5'd5; lu_wdata_i = 32'h55;
    cyc();
    lu_valid_i = 1'b0;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_wen",   32'(reg_wen_o),   32'd0);
    chk("arst_waddr", 32'(reg_waddr_o), 32'd0);
    chk("arst_wdata", reg_wdata_o,      32'd0);
    chk("arst_busy",  32'(busy_o),      32'd0);
    chk("arst_ready", 32'(lu_ready_o),  32'd1);
    ex_wen_i = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_wen", 32'(reg_wen_o), 32'd0);
    end

    // Random traffic; sources hold a request that was stalled or not accepted.
    for (int n = 0; n < 3000; n++) begin
      if (!stall_was) begin
        ex_wen_i   = ($urandom_range(0, 9) < 6);
        ex_waddr_i = 5'($urandom_range(0, 31));
        ex_wdata_i = $urandom;
      end
      if (!(lu_valid_i && !ready_was)) begin
        lu_valid_i = ($urandom_range(0, 99) < 45);
        lu_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lu_wdata_i = $urandom;
      end
      cyc();
    end
    ex_wen_i = 1'b0; lu_valid_i = 1'b0;
    repeat (12) cyc();
    chk("drain_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Writeback controller that drives the register-file write port (write address, write data, write enable) consumed by the register file.
- Merges two result sources: single-cycle EX results, and long-latency unit (LU) results (loads, divider) arriving over a valid/ready handshake.
- LU results are buffered in a small FIFO and drained when the write port is free.
- Arbitrates between the two sources and prevents LU starvation by requesting an EX stall.

Parameters:
FIFO_DEPTH, 2, LU result buffer entries; power of 2, minimum 2.
STARVE_MAX, 4, max consecutive cycles a FIFO head may lose arbitration before ex_stall_o asserts.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
ex_wen_i  in  1  EX result write request.
ex_waddr_i  in  5  EX destination register.
ex_wdata_i  in  32  EX result data.
lu_valid_i  in  1  LU result valid.
lu_ready_o  out  1  LU result accepted when valid & ready.
lu_waddr_i  in  5  LU destination register.
lu_wdata_i  in  32  LU result data.
reg_wen_o  out  1  register-file write enable (registered).
reg_waddr_o  out  5  register-file write address (registered).
reg_wdata_o  out  32  register-file write data (registered).
ex_stall_o  out  1  request upstream to hold the EX result for one cycle.
busy_o  out  1  FIFO non-empty.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count cleared; starve counter cleared.
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - lu_ready_o=1 once reset is released; ex_stall_o=0; busy_o=0.
  - Reset mid-operation discards all buffered entries, with no write issued.
- x0 filtering:
  - EX request with ex_waddr_i==0 is treated as no request.
  - LU handshake with lu_waddr_i==0 completes (ready honoured) but pushes nothing.
- Push:
  - lu_ready_o = !full, combinational from the count only.
  - When full, no push occurs, even if a pop happens the same cycle.
  - A push on edge N makes the entry eligible for arbitration in cycle N+1.
- Arbitration (combinational select, result registered at the next edge):
  - If ex_stall_o=0 and an EX request is valid: EX wins; reg_* load EX values.
  - Else if FIFO non-empty: pop head; reg_* load head values.
  - Else: reg_wen_o loads 0; reg_waddr_o and reg_wdata_o hold their previous values.
- Latency:
  - EX: 1 edge, request cycle N, write visible cycle N+1.
  - LU through empty FIFO: 2 edges.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and its head loses to EX.
  - Counter clears on pop or when the FIFO is empty.
  - ex_stall_o = (counter == STARVE_MAX), combinational.
  - While ex_stall_o=1 the FIFO head wins. Upstream holds ex_* stable; the EX request is not consumed that cycle.
  - The counter saturates at STARVE_MAX and clears on the resulting pop.
- Simultaneous push and pop (not full): count unchanged; pointers wrap modulo FIFO_DEPTH.
- Ordering:
  - FIFO drains strictly in order.
  - No WAW check between the EX and LU sources; the issue scoreboard guarantees no overlapping destinations.
- busy_o = (count != 0).

Optional Feature:
Macro WB_LU_BYPASS_EN.
- Defined: when the FIFO is empty, there is no EX request (or ex_stall_o=0 and EX is invalid), and an LU handshake with nonzero address occurs, the LU result loads reg_* directly at that edge and is not pushed. LU latency is then 1 edge.
- Undefined: all LU results pass through the FIFO; minimum latency 2 edges.

Test Plan:
- Reset then EX write x5=0x12345678 at cycle 3 → cycle 4 shows reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0x12345678; cycle 5 shows reg_wen_o=0.
- LU push x7=0xDEADBEEF with EX idle (bypass off) → write appears 2 edges later; busy_o=1 for exactly 1 cycle.
- Two LU pushes (x1=0x1, x2=0x2) with EX writing x10 every cycle, STARVE_MAX=4:
  - After 4 lost cycles ex_stall_o=1; x1 is written; the held x10 write follows.
  - Counter restarts, and x2 is later written after 4 more lost cycles.
- Fill FIFO (2 entries) while EX is busy → lu_ready_o=0; a third valid is held until a pop; drain order is preserved.
- EX write x0 and LU push x0 → no reg_wen_o pulse; LU handshake still completes; busy_o stays 0.
- Assert rst asynchronously with 2 buffered entries → outputs 0 immediately; after release no writes issue and lu_ready_o=1.
